// File: rtl/rr_arbiter3.sv
// Three-requester round-robin arbiter with registered one-hot grant held until done/req drop.
// Optional forced release after HOLD_MAX grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter3 #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] grant_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {StIdle, StGrant} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [1:0]         id_q, id_d;
    logic [1:0]         last_q, last_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [2:0]         mask_q, mask_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic [2:0]         eligible;
    logic [1:0]         cand1, cand2, win;
    logic               owner_req;
    logic               hold_hit;

    if (HOLD_MAX < 2 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_hold
        $error("rr_arbiter3: HOLD_MAX out of range for CNT_W");
    end

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign eligible  = req & ~mask_q;
    assign cand1     = inc3(last_q);
    assign cand2     = inc3(cand1);
    assign owner_req = |(req & grant_q);

    // Search order last+1, last+2, last.
    always_comb begin
        win = last_q;
        if (eligible[cand1]) begin
            win = cand1;
        end else if (eligible[cand2]) begin
            win = cand2;
        end
    end

`ifdef ARB_TIMEOUT_EN
    assign hold_hit = (hold_q == CNT_W'(HOLD_MAX - 1));
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        last_d    = last_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        mask_d    = mask_q & req;
`else
        mask_d    = 3'b000;
`endif
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StGrant;
                    grant_d = 3'b001 << win;
                    id_d    = win;
                    last_d  = win;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (done || !owner_req || hold_hit) begin
                    state_d = StIdle;
                    grant_d = 3'b000;
                    id_d    = 2'd3;
                    // Only a pure timeout (owner still requesting, no done) is a forced release.
                    if (hold_hit && !done && owner_req) begin
                        timeout_d = 1'b1;
                        mask_d    = mask_d | grant_q;
                    end
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StGrant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= 3'b000;
            id_q      <= 2'd3;
            last_q    <= 2'd2;
            hold_q    <= '0;
            mask_q    <= 3'b000;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = busy_q;
    assign timeout  = timeout_q;

endmodule
